adder_share_ctrl: RTL
=====================

ADDER_SHARE_CTRL -- requirements
Module: adder_share_ctrl

Interface
REQ-001 Parameter N, default 64, operand/result width in bits.
REQ-002 Parameter CHUNK, default 16, adder slice width per cycle; N SHALL be an integer multiple of CHUNK.
REQ-003 Parameter R, default 4, number of requesters; ID width IW = clog2(R), minimum 1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  R  per-requester operation request.
REQ-007 req_ready  output  R  per-requester accept, one-hot or zero.
REQ-008 req_a, req_b  input  R*N each  operands, requester i at bits [i*N +: N].
REQ-009 req_cin  input  R  carry-in per requester.
REQ-010 req_signed  input  R  signed-interpretation enable per requester.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  consumer accepts result.
REQ-013 rsp_id  output  IW  index of requester owning the result.
REQ-014 rsp_sum  output  N  result; rsp_cout, rsp_neg, rsp_ovf, rsp_zero  output  1 each  flags.

Function
REQ-015 Block SHALL share one CHUNK-bit adder slice among R requesters, with FSM states IDLE, CALC, RESP.
REQ-016 IDLE: req_ready SHALL be driven combinationally to a one-hot grant of the first requester with req_valid high, searched round-robin starting at index ptr; zero if none valid.
REQ-017 A request is accepted when req_valid[i] and req_ready[i] are both high at a rising edge; operands, cin, signed flag and i SHALL be latched, slice counter cleared, FSM -> CALC.
REQ-018 ptr SHALL update to (i+1) mod R on acceptance only; ptr unchanged otherwise.
REQ-019 req_ready SHALL be all-zero in CALC and RESP.
REQ-020 CALC: each cycle k (0..N/CHUNK-1) SHALL add slice k of a and b plus the stored carry (cin for k=0), write slice k of the sum register, store slice carry-out.
REQ-021 After slice N/CHUNK-1 the FSM SHALL enter RESP; total accept-to-rsp_valid latency = N/CHUNK+1 cycles (5 at defaults).
REQ-022 Result: rsp_sum = (a + b + cin) mod 2^N; rsp_cout = carry out of bit N-1.
REQ-023 Signed mode: rsp_neg = rsp_sum[N-1]; rsp_ovf = 1 iff a[N-1]==b[N-1] and rsp_sum[N-1]!=a[N-1].
REQ-024 Unsigned mode: rsp_neg = 0; rsp_ovf = rsp_cout.
REQ-025 rsp_zero = 1 iff rsp_sum == 0, in both modes.
REQ-026 RESP: rsp_valid high; rsp_id, rsp_sum and flags SHALL be stable until handshake.
REQ-027 rsp_valid and rsp_ready high at an edge -> FSM -> IDLE; rsp_valid low next cycle; no back-to-back acceptance in that same edge.
REQ-028 Outputs rsp_sum and flags SHALL hold last value outside RESP; rsp_valid low outside RESP.
REQ-029 req_valid deassertion before acceptance SHALL withdraw the request with no side effects.

Reset
REQ-030 rst high SHALL immediately force FSM IDLE, ptr 0, slice counter 0, rsp_valid 0, rsp_sum 0, rsp_id 0, all flags 0, stored carry 0.
REQ-031 rst asserted mid-CALC or mid-RESP SHALL discard the operation; no response emitted after release.
REQ-032 req_ready SHALL be all-zero while rst is high.

Verification
REQ-033 Unsigned: req 0, a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> after 5 cycles rsp_sum=0, rsp_cout=1, rsp_zero=1, rsp_ovf=1, rsp_neg=0, rsp_id=0.
REQ-034 Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, signed=1 -> rsp_sum=0x8000_0000_0000_0000, rsp_neg=1, rsp_ovf=1, rsp_cout=0.
REQ-035 Carry across slices: a=0x0000_0000_0000_FFFF, b=0, cin=1 -> rsp_sum=0x0000_0000_0001_0000, all flags 0.
REQ-036 Round-robin: requesters 0..3 all valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each result tagged with correct rsp_id.
REQ-037 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid and data stable, req_ready all-zero; release -> IDLE next cycle.
REQ-038 Reset mid-CALC (slice 2) -> rsp_valid stays 0, ptr=0; following request to req 2 completes normally.

Source files
------------

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: shares one CHUNK-bit adder slice among R requesters.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_a/req_b/
//   req_cin/req_signed per requester; rsp_valid/rsp_ready handshake with
//   rsp_id, rsp_sum and flags rsp_cout/rsp_neg/rsp_ovf/rsp_zero.
module adder_share_ctrl #(
   parameter int N     = 64,
   parameter int CHUNK = 16,
   parameter int R     = 4,
   localparam int IW   = (R > 1) ? $clog2(R) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [R-1:0]    req_valid,
   output logic [R-1:0]    req_ready,
   input  logic [R*N-1:0]  req_a,
   input  logic [R*N-1:0]  req_b,
   input  logic [R-1:0]    req_cin,
   input  logic [R-1:0]    req_signed,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [IW-1:0]   rsp_id,
   output logic [N-1:0]    rsp_sum,
   output logic            rsp_cout,
   output logic            rsp_neg,
   output logic            rsp_ovf,
   output logic            rsp_zero
);

   localparam int NS = N / CHUNK;
   localparam int CW = (NS > 1) ? $clog2(NS) : 1;

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t         state, state_d;
   logic [IW-1:0]  ptr;
   logic [IW-1:0]  gnt_idx;
   logic [R-1:0]   grant;
   logic [CW-1:0]  cnt;
   logic [IW-1:0]  id_q;
   logic [N-1:0]   a_q, b_q;
   logic [N-1:0]   sum_w, sum_next;
   logic           carry, sgn_q;
   logic [CHUNK:0] slice_sum;
   logic           accept, last, rsp_fire;

   // Round-robin search: first valid requester at or after ptr.
   always_comb begin
      int idx;
      logic found;
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < R; k++) begin
         idx = (int'(ptr) + k) % R;
         if (!found && req_valid[idx]) begin
            found        = 1'b1;
            grant[idx]   = 1'b1;
            gnt_idx      = IW'(idx);
         end
      end
   end

   assign req_ready = (state == IDLE && !rst) ? grant : '0;
   assign accept    = |req_ready;
   assign rsp_valid = (state == RESP);
   assign rsp_fire  = rsp_valid & rsp_ready;
   assign last      = (cnt == CW'(NS - 1));

   // One shared slice adder; carry holds cin for slice 0.
   assign slice_sum = {1'b0, a_q[cnt*CHUNK +: CHUNK]}
                    + {1'b0, b_q[cnt*CHUNK +: CHUNK]}
                    + (CHUNK+1)'(carry);

   // Working sum with the current slice merged in.
   always_comb begin
      sum_next = sum_w;
      sum_next[cnt*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (accept)   state_d = CALC;
         CALC:    if (last)     state_d = RESP;
         RESP:    if (rsp_fire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         cnt      <= '0;
         id_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sum_w    <= '0;
         carry    <= 1'b0;
         sgn_q    <= 1'b0;
         rsp_id   <= '0;
         rsp_sum  <= '0;
         rsp_cout <= 1'b0;
         rsp_neg  <= 1'b0;
         rsp_ovf  <= 1'b0;
         rsp_zero <= 1'b0;
      end else begin
         if (accept) begin
            a_q   <= req_a[gnt_idx*N +: N];
            b_q   <= req_b[gnt_idx*N +: N];
            carry <= req_cin[gnt_idx];
            sgn_q <= req_signed[gnt_idx];
            id_q  <= gnt_idx;
            cnt   <= '0;
            sum_w <= '0;
            ptr   <= IW'((int'(gnt_idx) + 1) % R);
         end
         if (state == CALC) begin
            sum_w <= sum_next;
            carry <= slice_sum[CHUNK];
            cnt   <= last ? '0 : cnt + 1'b1;
            if (last) begin
               rsp_id   <= id_q;
               rsp_sum  <= sum_next;
               rsp_cout <= slice_sum[CHUNK];
               rsp_zero <= (sum_next == '0);
               if (sgn_q) begin
                  rsp_neg <= sum_next[N-1];
                  rsp_ovf <= (a_q[N-1] == b_q[N-1]) &&
                             (sum_next[N-1] != a_q[N-1]);
               end else begin
                  rsp_neg <= 1'b0;
                  rsp_ovf <= slice_sum[CHUNK];
               end
            end
         end
      end
   end

endmodule
